// File: rtl/qbus_cycle_if.sv
// rtl/qbus_cycle_if.sv - Q-bus cycle sequencer request/response and bus pin bundle
// All bus signals are active-high; the board's inverting pin drivers sit outside.
interface qbus_cycle_if #(
    parameter int ADDR_WIDTH = 22
);
    logic                   req_stb;
    logic [2:0]             req_op;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic                   req_bs;
    logic [15:0]            req_data;
    logic                   req_busy;
    logic                   done_stb;
    logic                   done_err;
    logic [15:0]            rd_data;
    logic [15:0]            bus_ad_out;
    logic [ADDR_WIDTH-17:0] bus_ah_out;
    logic                   bus_ad_oe;
    logic                   bus_bs;
    logic [15:0]            bus_ad_in;
    logic                   bus_sync;
    logic                   bus_din;
    logic                   bus_dout;
    logic                   bus_wtbt;
    logic                   bus_iako;
    logic                   bus_rply;

    modport master (
        input  req_stb, req_op, req_addr, req_bs, req_data, bus_ad_in, bus_rply,
        output req_busy, done_stb, done_err, rd_data,
        output bus_ad_out, bus_ah_out, bus_ad_oe, bus_bs,
        output bus_sync, bus_din, bus_dout, bus_wtbt, bus_iako
    );

    modport slave (
        output req_stb, req_op, req_addr, req_bs, req_data, bus_ad_in, bus_rply,
        input  req_busy, done_stb, done_err, rd_data,
        input  bus_ad_out, bus_ah_out, bus_ad_oe, bus_bs,
        input  bus_sync, bus_din, bus_dout, bus_wtbt, bus_iako
    );
endinterface

// File: rtl/qbus_cycle.sv
// rtl/qbus_cycle.sv - Q-bus master cycle sequencer (DATI/DATO/DATOB/DATIO/DATIOB/IAKO)
// One request at a time; all outputs registered, RPLY double-synchronised.
module qbus_cycle #(
    parameter int ADDR_WIDTH = 22,
    parameter int TMO_WIDTH  = 6,
    parameter int SETUP      = 2
) (
    input  logic         pin_clk,
    input  logic         pin_rst,
    qbus_cycle_if.master q
);
    localparam logic [2:0] OP_DATI   = 3'd0;
    localparam logic [2:0] OP_DATO   = 3'd1;
    localparam logic [2:0] OP_DATOB  = 3'd2;
    localparam logic [2:0] OP_DATIO  = 3'd3;
    localparam logic [2:0] OP_DATIOB = 3'd4;
    localparam logic [2:0] OP_IAKO   = 3'd5;
    localparam logic [2:0] SETUP_CNT = 3'(SETUP);
    // Reaching all-ones is detected one count early so the strobe lasts exactly 2^N-1 clocks.
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = {{(TMO_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [3:0] {IDLE, ADR, SYN, RD, RDW, WS, WR, WRW, END} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             scnt_q, scnt_d;
    logic [TMO_WIDTH-1:0]   tcnt_q, tcnt_d;
    logic [2:0]             op_q, op_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   bs_q, bs_d;
    logic [15:0]            data_q, data_d;
    logic                   rply_m_q, rply_m_d;
    logic                   rply_s_q, rply_s_d;
    logic                   req_busy_q, req_busy_d;
    logic                   done_stb_q, done_stb_d;
    logic                   done_err_q, done_err_d;
    logic [15:0]            rd_data_q, rd_data_d;
    logic [15:0]            bus_ad_out_q, bus_ad_out_d;
    logic [ADDR_WIDTH-17:0] bus_ah_out_q, bus_ah_out_d;
    logic                   bus_ad_oe_q, bus_ad_oe_d;
    logic                   bus_bs_q, bus_bs_d;
    logic                   bus_sync_q, bus_sync_d;
    logic                   bus_din_q, bus_din_d;
    logic                   bus_dout_q, bus_dout_d;
    logic                   bus_wtbt_q, bus_wtbt_d;
    logic                   bus_iako_q, bus_iako_d;

    logic go_ws, fin, fin_err, tmo;
    logic is_byte, is_rmw;

    assign is_byte = (op_q == OP_DATOB) || (op_q == OP_DATIOB);
    assign is_rmw  = (op_q == OP_DATIO) || (op_q == OP_DATIOB);

    always_comb begin
        state_d      = state_q;
        scnt_d       = scnt_q;
        tcnt_d       = tcnt_q;
        op_d         = op_q;
        addr_d       = addr_q;
        bs_d         = bs_q;
        data_d       = data_q;
        rply_m_d     = q.bus_rply;
        rply_s_d     = rply_m_q;
        req_busy_d   = req_busy_q;
        done_stb_d   = 1'b0;
        done_err_d   = 1'b0;
        rd_data_d    = rd_data_q;
        bus_ad_out_d = bus_ad_out_q;
        bus_ah_out_d = bus_ah_out_q;
        bus_ad_oe_d  = bus_ad_oe_q;
        bus_bs_d     = bus_bs_q;
        bus_sync_d   = bus_sync_q;
        bus_din_d    = bus_din_q;
        bus_dout_d   = bus_dout_q;
        bus_wtbt_d   = bus_wtbt_q;
        bus_iako_d   = bus_iako_q;
        go_ws        = 1'b0;
        fin          = 1'b0;
        fin_err      = 1'b0;
        tmo          = 1'b0;

        unique case (state_q)
            IDLE, END: begin
                state_d = IDLE;
                if (q.req_stb) begin
                    state_d    = ADR;
                    scnt_d     = 3'd0;
                    op_d       = q.req_op;
                    addr_d     = q.req_addr;
                    bs_d       = q.req_bs;
                    data_d     = q.req_data;
                    req_busy_d = 1'b1;
                    rd_data_d  = 16'h0000;
                end
            end
            ADR: begin
                if (op_q > OP_IAKO) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (op_q == OP_IAKO) begin
                    state_d   = RD;
                    bus_din_d = 1'b1;
                    tcnt_d    = '0;
                end else begin
                    bus_ad_oe_d  = 1'b1;
                    bus_ad_out_d = addr_q[15:0];
                    bus_ah_out_d = addr_q[ADDR_WIDTH-1:16];
                    bus_bs_d     = bs_q;
                    bus_wtbt_d   = (op_q != OP_DATI);
                    if (scnt_q == SETUP_CNT) begin
                        state_d    = SYN;
                        bus_sync_d = 1'b1;
                    end else begin
                        scnt_d = scnt_q + 3'd1;
                    end
                end
            end
            SYN: begin
                if (op_q == OP_DATO || op_q == OP_DATOB) begin
                    go_ws = 1'b1;
                end else begin
                    state_d     = RD;
                    bus_ad_oe_d = 1'b0;
                    bus_din_d   = 1'b1;
                    tcnt_d      = '0;
                end
            end
            RD: begin
                if (rply_s_q) begin
                    state_d    = RDW;
                    rd_data_d  = q.bus_ad_in;
                    bus_din_d  = 1'b0;
                    bus_iako_d = 1'b0;
                    tcnt_d     = '0;
                end else if (tcnt_q == TMO_LAST) begin
                    tmo = 1'b1;
                end else begin
                    tcnt_d     = tcnt_q + 1'b1;
                    bus_iako_d = (op_q == OP_IAKO);
                end
            end
            RDW: begin
                if (!rply_s_q) begin
                    if (is_rmw) go_ws = 1'b1;
                    else        fin   = 1'b1;
                end else if (tcnt_q == TMO_LAST) begin
                    tmo = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            WS: begin
                if (scnt_q == SETUP_CNT) begin
                    state_d    = WR;
                    bus_dout_d = 1'b1;
                    tcnt_d     = '0;
                end else begin
                    scnt_d = scnt_q + 3'd1;
                end
            end
            WR: begin
                if (rply_s_q) begin
                    state_d    = WRW;
                    bus_dout_d = 1'b0;
                    tcnt_d     = '0;
                end else if (tcnt_q == TMO_LAST) begin
                    tmo = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            WRW: begin
                if (!rply_s_q)               fin    = 1'b1;
                else if (tcnt_q == TMO_LAST) tmo    = 1'b1;
                else                         tcnt_d = tcnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Data phase entry is shared by DATO/DATOB (from SYN) and the RMW ops (from RDW).
        if (go_ws) begin
            state_d      = WS;
            scnt_d       = 3'd1;
            bus_ad_oe_d  = 1'b1;
            bus_ad_out_d = data_q;
            bus_wtbt_d   = is_byte;
        end

        if (fin || tmo) begin
            state_d      = END;
            req_busy_d   = 1'b0;
            done_stb_d   = 1'b1;
            done_err_d   = fin_err | tmo;
            bus_ad_out_d = 16'h0000;
            bus_ah_out_d = '0;
            bus_ad_oe_d  = 1'b0;
            bus_bs_d     = 1'b0;
            bus_sync_d   = 1'b0;
            bus_din_d    = 1'b0;
            bus_dout_d   = 1'b0;
            bus_wtbt_d   = 1'b0;
            bus_iako_d   = 1'b0;
            if (tmo) rd_data_d = 16'h0000;
        end
    end

    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            state_q      <= IDLE;
            scnt_q       <= 3'd0;
            tcnt_q       <= '0;
            op_q         <= 3'd0;
            addr_q       <= '0;
            bs_q         <= 1'b0;
            data_q       <= 16'h0000;
            rply_m_q     <= 1'b0;
            rply_s_q     <= 1'b0;
            req_busy_q   <= 1'b0;
            done_stb_q   <= 1'b0;
            done_err_q   <= 1'b0;
            rd_data_q    <= 16'h0000;
            bus_ad_out_q <= 16'h0000;
            bus_ah_out_q <= '0;
            bus_ad_oe_q  <= 1'b0;
            bus_bs_q     <= 1'b0;
            bus_sync_q   <= 1'b0;
            bus_din_q    <= 1'b0;
            bus_dout_q   <= 1'b0;
            bus_wtbt_q   <= 1'b0;
            bus_iako_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            scnt_q       <= scnt_d;
            tcnt_q       <= tcnt_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            bs_q         <= bs_d;
            data_q       <= data_d;
            rply_m_q     <= rply_m_d;
            rply_s_q     <= rply_s_d;
            req_busy_q   <= req_busy_d;
            done_stb_q   <= done_stb_d;
            done_err_q   <= done_err_d;
            rd_data_q    <= rd_data_d;
            bus_ad_out_q <= bus_ad_out_d;
            bus_ah_out_q <= bus_ah_out_d;
            bus_ad_oe_q  <= bus_ad_oe_d;
            bus_bs_q     <= bus_bs_d;
            bus_sync_q   <= bus_sync_d;
            bus_din_q    <= bus_din_d;
            bus_dout_q   <= bus_dout_d;
            bus_wtbt_q   <= bus_wtbt_d;
            bus_iako_q   <= bus_iako_d;
        end
    end

    assign q.req_busy   = req_busy_q;
    assign q.done_stb   = done_stb_q;
    assign q.done_err   = done_err_q;
    assign q.rd_data    = rd_data_q;
    assign q.bus_ad_out = bus_ad_out_q;
    assign q.bus_ah_out = bus_ah_out_q;
    assign q.bus_ad_oe  = bus_ad_oe_q;
    assign q.bus_bs     = bus_bs_q;
    assign q.bus_sync   = bus_sync_q;
    assign q.bus_din    = bus_din_q;
    assign q.bus_dout   = bus_dout_q;
    assign q.bus_wtbt   = bus_wtbt_q;
    assign q.bus_iako   = bus_iako_q;
endmodule

// File: tb/tb_qbus_cycle.sv
// tb/tb_qbus_cycle.sv - scoreboard bench for qbus_cycle with a delayed-reply slave
// Directed cycles; completions checked by a done_stb monitor, strobe timing by a recorder.
module tb_qbus_cycle;
    localparam logic [2:0] OP_DATI  = 3'd0;
    localparam logic [2:0] OP_DATO  = 3'd1;
    localparam logic [2:0] OP_DATOB = 3'd2;
    localparam logic [2:0] OP_DATIO = 3'd3;
    localparam logic [2:0] OP_IAKO  = 3'd5;

    logic clk = 1'b0;
    logic rst;

    qbus_cycle_if #(.ADDR_WIDTH(22)) q ();

    qbus_cycle #(.ADDR_WIDTH(22), .TMO_WIDTH(4), .SETUP(2)) dut (
        .pin_clk (clk),
        .pin_rst (rst),
        .q       (q)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [15:0] rd;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    logic        slave_en   = 1'b0;
    int          slave_dly  = 0;
    logic [15:0] slave_data = 16'h0000;
    int          slave_cnt  = 0;

    int end_k, sync_first, sync_rises, din_first, din_cnt, dout_first, dout_cnt;
    int iako_first, ws_cnt;
    logic any_strobe, wtbt_any, wtbt_k1, bs_k1, wtbt_dout, sync_dout;
    logic [15:0] ad_k1, ad_dout;
    logic [5:0]  ah_k1, end_bus;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave: answers any DIN/DOUT after slave_dly falling edges, releases RPLY once the strobe drops.
    always @(negedge clk) begin
        if (!slave_en) begin
            q.bus_rply = 1'b0;
            q.bus_ad_in = 16'h0000;
            slave_cnt = 0;
        end else if (!q.bus_rply) begin
            if (q.bus_din || q.bus_dout) begin
                if (slave_cnt >= slave_dly) begin
                    q.bus_rply  = 1'b1;
                    q.bus_ad_in = slave_data;
                    slave_cnt   = 0;
                end else begin
                    slave_cnt++;
                end
            end else begin
                slave_cnt = 0;
            end
        end else if (!q.bus_din && !q.bus_dout) begin
            q.bus_rply = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && q.done_stb) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected: got done_stb=1 expected none (err=%0b rd=0x%0h)", q.done_err, q.rd_data);
            end else begin
                e = sb_q.pop_front();
                chk("done_err", {31'd0, q.done_err}, {31'd0, e.err});
                chk("rd_data", {16'd0, q.rd_data}, {16'd0, e.rd});
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [21:0] addr, input logic bs,
                         input logic [15:0] data, input logic push, input logic err,
                         input logic [15:0] rd);
        q.req_op   = op;
        q.req_addr = addr;
        q.req_bs   = bs;
        q.req_data = data;
        q.req_stb  = 1'b1;
        @(posedge clk); #1;
        q.req_stb  = 1'b0;
        if (push) sb_q.push_back({err, rd});
        chk("busy_at_accept", {31'd0, q.req_busy}, 32'd1);
        chk("rd_clr_at_accept", {16'd0, q.rd_data}, 32'd0);
    endtask

    task automatic record(input int max_k, input logic [15:0] wdata);
        logic prev_sync;
        prev_sync = 1'b0;
        end_k = -1; sync_first = -1; sync_rises = 0; din_first = -1; din_cnt = 0;
        dout_first = -1; dout_cnt = 0; iako_first = -1; ws_cnt = 0;
        any_strobe = 1'b0; wtbt_any = 1'b0; wtbt_dout = 1'b0; sync_dout = 1'b0;
        ad_dout = 16'h0; end_bus = 6'h3F;
        for (int k = 1; k <= max_k; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                wtbt_k1 = q.bus_wtbt; bs_k1 = q.bus_bs;
                ad_k1 = q.bus_ad_out; ah_k1 = q.bus_ah_out;
            end
            if (q.bus_sync && !prev_sync) begin
                sync_rises++;
                if (sync_first < 0) sync_first = k;
            end
            prev_sync = q.bus_sync;
            if (q.bus_wtbt) wtbt_any = 1'b1;
            if (q.bus_din) begin
                din_cnt++;
                if (din_first < 0) din_first = k;
            end
            if (q.bus_dout) begin
                dout_cnt++;
                if (dout_first < 0) begin
                    dout_first = k; wtbt_dout = q.bus_wtbt;
                    ad_dout = q.bus_ad_out; sync_dout = q.bus_sync;
                end
            end
            if (q.bus_iako && iako_first < 0) iako_first = k;
            if (dout_first < 0 && q.bus_ad_oe && q.bus_sync && q.bus_ad_out == wdata) ws_cnt++;
            if (q.bus_sync | q.bus_din | q.bus_dout | q.bus_iako | q.bus_ad_oe) any_strobe = 1'b1;
            if (!q.req_busy) begin
                end_k = k;
                end_bus = {q.bus_sync, q.bus_din, q.bus_dout, q.bus_iako, q.bus_ad_oe, q.bus_wtbt};
                break;
            end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ctl"}, {22'd0, q.req_busy, q.done_stb, q.done_err, q.bus_ad_oe, q.bus_bs,
                            q.bus_sync, q.bus_din, q.bus_dout, q.bus_wtbt, q.bus_iako}, 32'd0);
        chk({tag, "_data"}, {q.rd_data, q.bus_ad_out}, 32'd0);
        chk({tag, "_ah"}, {26'd0, q.bus_ah_out}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        q.req_stb = 1'b0; q.req_op = 3'd0; q.req_addr = 22'd0; q.req_bs = 1'b0; q.req_data = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // DATI 0x3FF00A, reply 3 clocks after DIN with 0o123456
        slave_en = 1'b1; slave_dly = 3; slave_data = 16'hA72E;
        issue(OP_DATI, 22'h3FF00A, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hA72E);
        record(60, 16'h0000);
        chk("dati_sync_first", sync_first, 3);
        chk("dati_sync_rises", sync_rises, 1);
        chk("dati_ad_k1", {16'd0, ad_k1}, 32'hF00A);
        chk("dati_ah_k1", {26'd0, ah_k1}, 32'h3F);
        chk("dati_wtbt", {31'd0, wtbt_any}, 32'd0);
        chk("dati_din_first", din_first, 4);
        chk("dati_din_cnt", din_cnt, 6);
        chk("dati_end_k", end_k, 13);

        // DATOB 0o177566, data 0x0041
        slave_dly = 0; slave_data = 16'h0000;
        issue(OP_DATOB, 22'o177566, 1'b1, 16'h0041, 1'b1, 1'b0, 16'h0000);
        record(60, 16'h0041);
        chk("datob_wtbt_adr", {31'd0, wtbt_k1}, 32'd1);
        chk("datob_bs_adr", {31'd0, bs_k1}, 32'd1);
        chk("datob_ws_cnt", ws_cnt, 2);
        chk("datob_dout_first", dout_first, 6);
        chk("datob_wtbt_data", {31'd0, wtbt_dout}, 32'd1);
        chk("datob_ad_dout", {16'd0, ad_dout}, 32'h0041);
        chk("datob_dout_cnt", dout_cnt, 3);
        chk("datob_end_k", end_k, 12);

        // DATIO 0o1000: read 0x1234, write 0x1235 under one SYNC
        slave_data = 16'h1234;
        issue(OP_DATIO, 22'o1000, 1'b0, 16'h1235, 1'b1, 1'b0, 16'h1234);
        record(60, 16'h1235);
        chk("datio_sync_rises", sync_rises, 1);
        chk("datio_wtbt_adr", {31'd0, wtbt_k1}, 32'd1);
        chk("datio_din_cnt", din_cnt, 3);
        chk("datio_dout_first", dout_first, 12);
        chk("datio_sync_at_dout", {31'd0, sync_dout}, 32'd1);
        chk("datio_wtbt_data", {31'd0, wtbt_dout}, 32'd0);
        chk("datio_ad_dout", {16'd0, ad_dout}, 32'h1235);
        chk("datio_end_k", end_k, 18);

        // DATI timeout with no slave
        slave_en = 1'b0;
        issue(OP_DATI, 22'h001000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000);
        record(60, 16'h0000);
        chk("tmo_din_cnt", din_cnt, 15);
        chk("tmo_end_k", end_k, 19);
        chk("tmo_end_bus", {26'd0, end_bus}, 32'd0);

        // IAKO vector 0o060
        slave_en = 1'b1; slave_dly = 1; slave_data = 16'o000060;
        issue(OP_IAKO, 22'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'o000060);
        record(60, 16'hFFFF);
        chk("iako_sync_rises", sync_rises, 0);
        chk("iako_din_first", din_first, 1);
        chk("iako_iako_first", iako_first, 2);
        chk("iako_din_cnt", din_cnt, 4);
        chk("iako_end_k", end_k, 8);

        // illegal op 7
        issue(3'd7, 22'h000200, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000);
        record(20, 16'hFFFF);
        chk("ill_end_k", end_k, 1);
        chk("ill_strobes", {31'd0, any_strobe}, 32'd0);

        // reset during DOUT aborts silently, then a normal DATO completes
        slave_en = 1'b0;
        issue(OP_DATO, 22'h000100, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 20 && !q.bus_dout; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_dout_reached", {31'd0, q.bus_dout}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_state("midrst");
        rst = 1'b0;
        slave_en = 1'b1; slave_dly = 0;
        issue(OP_DATO, 22'h000100, 1'b0, 16'hBEEF, 1'b1, 1'b0, 16'h0000);
        record(60, 16'hBEEF);
        chk("post_rst_dout_cnt", dout_cnt, 3);
        chk("post_rst_end_k", end_k, 12);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        chk("done_count", done_cnt, 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached without completion");
        $fatal(1);
    end
endmodule

// File: doc/qbus_cycle.md
Name: qbus_cycle

Overview:
- Parametrised Q-bus master cycle sequencer. It replaces the fixed-equation SYNC/DIN/DOUT/IAKO/WTBT logic and the fixed 6-bit transaction timer of the F-11 board wrapper.
- Supports DATI, DATO, DATOB, DATIO and DATIOB (read-modify-write), plus IAKO vector reads.
- Address setup, data setup and timeout length are configurable.
- Sits between the CPU microbus interface and the inverting pin drivers; all bus signals here are active-high.

Parameters:
- ADDR_WIDTH, 22, bus address width, legal range 17..22.
- TMO_WIDTH, 6, timeout counter width; a cycle errors after 2^TMO_WIDTH-1 cycles of a strobe without RPLY change.
- SETUP, 2, clocks of address/data setup before SYNC or DOUT, legal range 1..7.

Ports:
- pin_clk  in  1  processor clock; all logic on rising edge.
- pin_rst  in  1  synchronous active-high reset.
- req_stb  in  1  start request; sampled only when req_busy=0.
- req_op  in  3  0=DATI, 1=DATO, 2=DATOB, 3=DATIO, 4=DATIOB, 5=IAKO; 6 and 7 are illegal.
- req_addr  in  ADDR_WIDTH  cycle address.
- req_bs  in  1  I/O bank select, driven with the address.
- req_data  in  16  write data, captured at accept.
- req_busy  out  1  cycle in progress.
- done_stb  out  1  one-clock completion pulse.
- done_err  out  1  valid with done_stb; 1 means timeout or illegal op.
- rd_data  out  16  read data or vector; held until the next accept.
- bus_ad_out  out  16  address/data output.
- bus_ah_out  out  ADDR_WIDTH-16  high address bits.
- bus_ad_oe  out  1  AD/A/BS driver enable.
- bus_bs  out  1  bank select.
- bus_ad_in  in  16  AD bus input.
- bus_sync, bus_din, bus_dout, bus_wtbt, bus_iako  out  1 each  bus strobes.
- bus_rply  in  1  asynchronous RPLY; passes through a 2-flop synchroniser (rply_s).

Behaviour:
- Reset: every output is 0, the FSM is IDLE and the timeout counter is 0. Reset applied mid-cycle drops all strobes and bus_ad_oe at the next edge, and no done_stb is issued.
- Accept at edge T when req_stb=1 and req_busy=0. At accept: req_busy=1, inputs are latched, rd_data is cleared to 0. req_stb while busy is ignored.
- Illegal op: no bus activity; done_stb=1 and done_err=1 at T+1.
- FSM states: IDLE, ADR, SYN, RD, RDW, WS, WR, WRW, END.
- ADR (address phase):
  - From T+1, bus_ad_oe=1 and address/bs are driven for SETUP clocks.
  - bus_wtbt=1 for DATO, DATOB, DATIO and DATIOB; 0 for DATI.
- SYN: bus_sync=1 and stays asserted until END.
- Read phase, entered the clock after SYN:
  - bus_ad_oe=0, bus_din=1.
  - In RD, wait for rply_s=1. On that edge latch rd_data<=bus_ad_in and drop bus_din.
  - In RDW, wait for rply_s=0.
- Write phase (DATO/DATOB directly after SYN; DATIO/DATIOB after RDW):
  - WS: bus_ad_oe=1, bus_ad_out=req_data, bus_wtbt=1 only for byte ops, held for SETUP clocks.
  - WR: bus_dout=1; wait for rply_s=1, then drop bus_dout.
  - WRW: wait for rply_s=0.
- END: bus_sync=0, bus_ad_oe=0, bus_wtbt=0; done_stb=1 and done_err=0. req_busy falls in the same clock, so a new accept is possible one clock after END.
- IAKO: no ADR or SYN phase; bus_sync stays 0.
  - bus_din=1 from T+1; bus_iako=1 from T+2.
  - Waits for rply_s=1, latches the vector into rd_data, drops DIN and IAKO, waits for rply_s=0, then END.
- Timeout:
  - The counter clears on entry to RD, RDW, WR and WRW, and increments every clock spent in those states.
  - When it reaches all-ones, drop all strobes and bus_ad_oe, set rd_data=0, go to END with done_err=1.
  - Counter wrap never occurs.
- RPLY already high on entry to RD or WR is treated as an immediate reply. The previous slave's reply must already be cleared, because RDW/WRW guarantee it.
- Simultaneous reply and timeout in the same clock: reply wins and done_err=0.

Test Plan:
- DATI, addr 0x3FF00A, slave replies 3 clocks after DIN with 0o123456 → SYNC at T+3 (SETUP=2), bus_wtbt=0, rd_data=0o123456, done_stb once, done_err=0.
- DATOB, addr 0o177566, data 0x0041 → wtbt=1 in address and data phases, bus_ad_out=0x0041 for 2 clocks before DOUT, DOUT drops on rply_s, done_err=0.
- DATIO to 0o1000, read 0x1234, write 0x1235 → single SYNC spanning both phases, DIN then DOUT, wtbt=0 in the data phase, rd_data=0x1234.
- Timeout, TMO_WIDTH=4, no RPLY on DATI → DIN held exactly 15 clocks, then all strobes 0, done_err=1, rd_data=0.
- IAKO, RPLY with vector 0o000060 → bus_sync never 1, IAKO one clock after DIN, rd_data=0o060. Then req_op=7 → done_err=1 at T+1 with no strobe activity.
- pin_rst asserted while DOUT=1 → next clock all outputs 0, no done_stb; the next request completes normally.
